// File: rtl/lsu_mem_responder.sv
// Clocked pmem slave for the LSU: one request at a time, fixed-latency response,
// 64-bit word storage with byte-lane merge on stores and zero-filled loads.
module lsu_mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] addr_q, wdata_q;
    logic        wen_q;
    logic [7:0]  mask_q;

    logic [63:0] mem [DEPTH];

    logic [63:0] cur_addr, cur_wdata, diff, word, shifted, wsh, merged, load_data;
    logic [63:0] rdata_n;
    logic        cur_wen, in_lo, in_range, legal, fault, commit;
    logic [7:0]  cur_mask;
    logic [15:0] bmask_sh;
    logic [3:0]  nbytes;
    logic [2:0]  off;
    logic [AW-1:0] idx;

    // With LATENCY=1 the commit happens on the acceptance edge, so decode the live request.
    always_comb begin
        cur_addr  = (state == IDLE) ? req_addr  : addr_q;
        cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
        cur_wen   = (state == IDLE) ? req_wen   : wen_q;
        cur_mask  = (state == IDLE) ? req_mask  : mask_q;
    end

    always_comb begin
        legal  = 1'b1;
        nbytes = 4'd0;
        case (cur_mask)
            8'h01:   nbytes = 4'd1;
            8'h03:   nbytes = 4'd2;
            8'h0F:   nbytes = 4'd4;
            8'hFF:   nbytes = 4'd8;
            default: legal  = 1'b0;
        endcase
    end

    // Subtract only above BASE so low addresses can never alias into storage.
    assign in_lo    = (cur_addr >= BASE);
    assign diff     = in_lo ? (cur_addr - BASE) : 64'd0;
    assign in_range = in_lo && (diff < SPAN);
    assign idx      = diff[AW+2:3];
    assign off      = cur_addr[2:0];
    assign fault    = !in_range || !legal || ((5'(off) + 5'(nbytes)) > 5'd8);

    assign word     = mem[idx];
    assign shifted  = word >> {off, 3'b000};
    assign wsh      = cur_wdata << {off, 3'b000};
    assign bmask_sh = 16'(cur_mask) << off;

    always_comb begin
        merged    = word;
        load_data = 64'd0;
        for (int j = 0; j < 8; j++) begin
            if (bmask_sh[j])  merged[8*j +: 8]    = wsh[8*j +: 8];
            if (cur_mask[j])  load_data[8*j +: 8] = shifted[8*j +: 8];
        end
    end

    assign rdata_n = (fault || cur_wen) ? 64'd0 : load_data;
    assign commit  = rst_n && (((state == WAIT) && (cnt == 4'd0)) ||
                               ((state == IDLE) && req_valid && (LATENCY == 1)));

    always_ff @(posedge clk) begin
        if (commit && cur_wen && !fault)
            mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            wen_q     <= 1'b0;
            mask_q    <= 8'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q    <= req_addr;
                    wdata_q   <= req_wdata;
                    wen_q     <= req_wen;
                    mask_q    <= req_mask;
                    req_ready <= 1'b0;
                    if (LATENCY == 1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_n;
                        rsp_err   <= fault;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: if (cnt == 4'd0) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rdata_n;
                    rsp_err   <= fault;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 64'd0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: word/sub-word access, merge, faults,
// response backpressure and reset abort, against hand-computed values.
module tb_lsu_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency, optionally stall the response, then retire it.
    task automatic xact(input string tag, input logic [63:0] a, input logic w,
                        input logic [63:0] d, input logic [7:0] m, input int stall,
                        input logic [63:0] exp_rd, input logic exp_err);
        int k;
        int lat;
        logic [63:0] rd;
        @(negedge clk);
        req_addr = a; req_wen = w; req_wdata = d; req_mask = m; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, ".lat"}, 64'(lat), 64'd2);
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, {63'd0, rsp_err}, {63'd0, exp_err});
        rd = rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                req_addr = 64'h8000_0010; req_wen = 1'b1; req_wdata = '1; req_mask = 8'hFF;
                req_valid = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk({tag, ".stall_vld"}, {63'd0, rsp_valid}, 64'd1);
            chk({tag, ".stall_data"}, rsp_rdata, rd);
            chk({tag, ".stall_rdy"}, {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".done_vld"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, ".done_rdy"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #12;
        chk("rst.ready", {63'd0, req_ready}, 64'd1);
        chk("rst.valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst.rdata", rsp_rdata, 64'd0);
        chk("rst.err", {63'd0, rsp_err}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        xact("st_word", 64'h8000_0010, 1'b1, 64'h1122334455667788, 8'hFF, 0, 64'd0, 1'b0);
        xact("ld_word", 64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, 64'h1122334455667788, 1'b0);
        xact("ld_half", 64'h8000_0012, 1'b0, 64'd0, 8'h03, 0, 64'h5566, 1'b0);
        xact("ld_byte", 64'h8000_0017, 1'b0, 64'd0, 8'h01, 0, 64'h11, 1'b0);
        xact("st_byte", 64'h8000_0014, 1'b1, 64'h0000_0000_0000_00AB, 8'h01, 0, 64'd0, 1'b0);
        xact("ld_merge", 64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, 64'h112233AB55667788, 1'b0);

        xact("f_low", 64'h7FFF_FFF8, 1'b1, 64'hDEAD, 8'hFF, 0, 64'd0, 1'b1);
        xact("f_high", 64'h8000_2000, 1'b0, 64'd0, 8'hFF, 0, 64'd0, 1'b1);
        xact("f_mask", 64'h8000_0010, 1'b1, '1, 8'h05, 0, 64'd0, 1'b1);
        xact("f_cross", 64'h8000_0016, 1'b1, '1, 8'h0F, 0, 64'd0, 1'b1);
        xact("f_cross_ld", 64'h8000_0016, 1'b0, 64'd0, 8'h0F, 0, 64'd0, 1'b1);
        xact("f_after", 64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, 64'h112233AB55667788, 1'b0);

        // The stalled load also carries a stray store pulse that must be ignored.
        xact("bp", 64'h8000_0010, 1'b0, 64'd0, 8'hFF, 5, 64'h112233AB55667788, 1'b0);
        xact("bp_after", 64'h8000_0010, 1'b0, 64'd0, 8'hFF, 0, 64'h112233AB55667788, 1'b0);

        xact("st_20", 64'h8000_0020, 1'b1, 64'h0BAD_F00D_CAFE_BEEF, 8'hFF, 0, 64'd0, 1'b0);
        @(negedge clk);
        req_addr = 64'h8000_0020; req_wen = 1'b1; req_wdata = 64'h5555_5555_5555_5555;
        req_mask = 8'hFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_wait.in_wait", {63'd0, req_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait.ready", {63'd0, req_ready}, 64'd1);
        chk("rst_wait.valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_wait.rdata", rsp_rdata, 64'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        xact("ld_20", 64'h8000_0020, 1'b0, 64'd0, 8'hFF, 0, 64'h0BAD_F00D_CAFE_BEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
